// File: rtl/coletor_pin.sv
// Keypad PIN collector: gathers four digits from single key strobes and issues one
// pinPac_t packet with a one-cycle status strobe; handles clear, short entry and timeout.

package coletor_pin_pkg;

  typedef struct packed {
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic       status;
  } pinPac_t;

endpackage

module coletor_pin
  import coletor_pin_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [2:0] digit_count,
  output logic       entry_error,
  output logic       timeout
);

  localparam int unsigned TmrWidth = $clog2(TIMEOUT_CYCLES) + 1;
  // Expiry is decided when the incremented count would reach TIMEOUT_CYCLES-1.
  localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(TIMEOUT_CYCLES - 2);

  localparam logic [3:0] KeyClear = 4'hA;
  localparam logic [3:0] KeyEnter = 4'hB;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e              state_q, state_d;
  logic [15:0]         buf_q, buf_d;
  logic [2:0]          count_q, count_d;
  logic [TmrWidth-1:0] tmr_q, tmr_d;
  pinPac_t             pin_q, pin_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  logic is_digit;
  assign is_digit = (key_code <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      count_q <= '0;
      tmr_q   <= '0;
      pin_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      tmr_q   <= tmr_d;
      pin_q   <= pin_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    count_d       = count_q;
    tmr_d         = '0;
    pin_d         = pin_q;
    pin_d.status  = 1'b0;
    err_d         = 1'b0;
    to_d          = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Buffer is already empty here, so clear and enter need no action.
        if (enable && key_valid && is_digit) begin
          buf_d   = {12'h000, key_code};
          count_d = 3'd1;
          state_d = StCollect;
        end
      end

      StCollect: begin
        if (!enable) begin
          buf_d   = '0;
          count_d = '0;
          state_d = StIdle;
        end else if (key_valid) begin
          if (is_digit) begin
            if (count_q < 3'd4) begin
              buf_d   = {buf_q[11:0], key_code};
              count_d = count_q + 3'd1;
            end
          end else if (key_code == KeyClear) begin
            buf_d   = '0;
            count_d = '0;
            state_d = StIdle;
          end else if (key_code == KeyEnter) begin
            if (count_q == 3'd4) begin
              pin_d.digit4 = buf_q[15:12];
              pin_d.digit3 = buf_q[11:8];
              pin_d.digit2 = buf_q[7:4];
              pin_d.digit1 = buf_q[3:0];
              pin_d.status = 1'b1;
              state_d      = StDone;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
            buf_d   = '0;
            count_d = '0;
          end
        end else if (tmr_q == TmrLast) begin
          buf_d   = '0;
          count_d = '0;
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + TmrWidth'(1);
        end
      end

      StDone: begin
        buf_d   = '0;
        count_d = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign pin_out     = pin_q;
  assign digit_count = count_q;
  assign entry_error = err_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_coletor_pin.sv
// Directed bench for coletor_pin: vector table for the main key sequences plus
// hand sequences for timeout, reset and enable handling.

module tb_coletor_pin;
  import coletor_pin_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_code;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       entry_error;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  coletor_pin #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pin_out    (pin_out),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        kv;
    logic [3:0]  code;
    logic [2:0]  cnt;
    logic        st;
    logic [15:0] dig;
    logic        err;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic kv, input logic [3:0] code,
                     input logic [2:0] cnt, input logic st, input logic [15:0] dig,
                     input logic err, input logic to);
    vec_t v;
    v.en = en; v.kv = kv; v.code = code; v.cnt = cnt;
    v.st = st; v.dig = dig; v.err = err; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic en, input logic kv, input logic [3:0] code);
    @(negedge clk);
    rst = r; enable = en; key_valid = kv; key_code = code;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digits();
    return {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1};
  endfunction

  task automatic chk_all(input string name, input logic [2:0] cnt, input logic st,
                         input logic [15:0] dig, input logic err, input logic to);
    chk({name, ".count"}, 32'(digit_count), 32'(cnt));
    chk({name, ".status"}, 32'(pin_out.status), 32'(st));
    chk({name, ".digits"}, 32'(digits()), 32'(dig));
    chk({name, ".error"}, 32'(entry_error), 32'(err));
    chk({name, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; key_valid = 1'b0; key_code = 4'h0;

    // Keys 1,2,3,4,enter then idle
    add(1, 1, 4'h1, 1, 0, 16'h0000, 0, 0);
    add(1, 1, 4'h2, 2, 0, 16'h0000, 0, 0);
    add(1, 1, 4'h3, 3, 0, 16'h0000, 0, 0);
    add(1, 1, 4'h4, 4, 0, 16'h0000, 0, 0);
    add(1, 1, 4'hB, 0, 1, 16'h1234, 0, 0);
    add(1, 0, 4'h0, 0, 0, 16'h1234, 0, 0);
    // Five digits, fifth ignored
    add(1, 1, 4'h9, 1, 0, 16'h1234, 0, 0);
    add(1, 1, 4'h8, 2, 0, 16'h1234, 0, 0);
    add(1, 1, 4'h7, 3, 0, 16'h1234, 0, 0);
    add(1, 1, 4'h6, 4, 0, 16'h1234, 0, 0);
    add(1, 1, 4'h5, 4, 0, 16'h1234, 0, 0);
    add(1, 1, 4'hB, 0, 1, 16'h9876, 0, 0);
    add(1, 0, 4'h0, 0, 0, 16'h9876, 0, 0);
    // Short entry
    add(1, 1, 4'h4, 1, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h2, 2, 0, 16'h9876, 0, 0);
    add(1, 1, 4'hB, 0, 0, 16'h9876, 1, 0);
    add(1, 0, 4'h0, 0, 0, 16'h9876, 0, 0);
    // Enter and ignored codes in idle
    add(1, 1, 4'hB, 0, 0, 16'h9876, 0, 0);
    add(1, 1, 4'hC, 0, 0, 16'h9876, 0, 0);
    // Clear mid-entry, then key right after the accepting enter
    add(1, 1, 4'h1, 1, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h2, 2, 0, 16'h9876, 0, 0);
    add(1, 1, 4'hA, 0, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h5, 1, 0, 16'h9876, 0, 0);
    add(1, 1, 4'hF, 1, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h6, 2, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h7, 3, 0, 16'h9876, 0, 0);
    add(1, 1, 4'h8, 4, 0, 16'h9876, 0, 0);
    add(1, 1, 4'hB, 0, 1, 16'h5678, 0, 0);
    add(1, 1, 4'h3, 0, 0, 16'h5678, 0, 0);
    add(1, 0, 4'h0, 0, 0, 16'h5678, 0, 0);

    step(1, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    chk_all("reset", 0, 0, 16'h0000, 0, 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].en, vecs[i].kv, vecs[i].code);
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].st, vecs[i].dig,
              vecs[i].err, vecs[i].to);
    end

    // Timeout: key at K, pulse visible after edge K+7
    step(0, 1, 1, 4'h7);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 4'h0);
      chk($sformatf("to1.pulse%0d", i), 32'(timeout), 32'(i == 7));
      chk($sformatf("to1.count%0d", i), 32'(digit_count), (i >= 7) ? 32'd0 : 32'd1);
    end

    // Ignored code reloads the counter
    step(0, 1, 1, 4'h7);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 4'h0);
    step(0, 1, 1, 4'hE);
    chk("to2.reload", 32'(timeout), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 4'h0);
      chk($sformatf("to2.pulse%0d", i), 32'(timeout), 32'(i == 7));
      chk($sformatf("to2.count%0d", i), 32'(digit_count), (i >= 7) ? 32'd0 : 32'd1);
    end

    // Reset mid-entry
    step(0, 1, 1, 4'h1);
    step(0, 1, 1, 4'h2);
    step(0, 1, 1, 4'h3);
    step(1, 1, 0, 4'h0);
    chk_all("rst_mid", 0, 0, 16'h0000, 0, 0);

    // Reset during DONE kills the issued packet
    step(0, 1, 1, 4'h2);
    step(0, 1, 1, 4'h4);
    step(0, 1, 1, 4'h6);
    step(0, 1, 1, 4'h8);
    step(0, 1, 1, 4'hB);
    chk_all("issue_2468", 0, 1, 16'h2468, 0, 0);
    step(1, 1, 0, 4'h0);
    chk_all("rst_done", 0, 0, 16'h0000, 0, 0);

    // Enable drop aborts silently; abort wins over a simultaneous key
    step(0, 1, 1, 4'h1);
    step(0, 1, 1, 4'h2);
    step(0, 0, 1, 4'h5);
    chk_all("abort", 0, 0, 16'h0000, 0, 0);
    step(0, 0, 1, 4'h3);
    chk_all("dis_digit", 0, 0, 16'h0000, 0, 0);
    step(0, 0, 1, 4'hB);
    chk_all("dis_enter", 0, 0, 16'h0000, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 4'h0);
    chk_all("dis_idle", 0, 0, 16'h0000, 0, 0);
    step(0, 1, 1, 4'h9);
    chk_all("reenable", 1, 0, 16'h0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coletor_pin.md
# coletor_pin

Keypad-side producer of the `pinPac_t` packet consumed by the password verifier. It turns a stream of single key events into one PIN packet of four digits and issues it with a single-cycle `status` strobe. It also handles clear, inactivity timeout and short-entry errors. It sits between the keypad scanner/debouncer and the verifier in the lock datapath.

## Interface
- `TIMEOUT_CYCLES`, default 5_000_000: idle cycles in an unfinished entry before it is discarded (≥2).
- `clk`  in  1  system clock; everything is registered on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  entry allowed; low forces abort to IDLE (e.g. lock blocked or in setup).
- `key_valid`  in  1  one-cycle strobe: `key_code` is valid this cycle.
- `key_code`  in  4  0x0–0x9 digit, 0xA clear (`*`), 0xB enter (`#`), 0xC–0xF ignored.
- `pin_out`  out  pinPac_t  `digit4..digit1` (4 bits each) plus `status`; `status` is the valid strobe.
- `digit_count`  out  3  digits currently buffered (0–4), for the display.
- `entry_error`  out  1  one-cycle pulse: enter pressed with fewer than 4 digits.
- `timeout`  out  1  one-cycle pulse: partial entry discarded for inactivity.

## Operation
- States:
  - IDLE: buffer empty, count 0.
  - COLLECT: 1–4 digits buffered.
  - DONE: one cycle, packet being issued.
- Digit accepted (`enable`=1, `key_valid`=1, code ≤ 9, count < 4):
  - The buffer shifts left: digit4←digit3, digit3←digit2, digit2←digit1, digit1←new.
  - Count increments. IDLE→COLLECT.
  - Keying 1,2,3,4 therefore gives digit4=1 … digit1=4, i.e. concatenated vector 0x1234.
- Digit while count = 4: ignored; buffer unchanged; the timeout counter is still reloaded.
- Clear (0xA) in IDLE/COLLECT: buffer zeroed, count 0, →IDLE, no pulse.
- Enter (0xB):
  - Count = 4: `pin_out` digits load from the buffer, `status`=1, →DONE.
  - Count 1–3: `entry_error` pulse, buffer cleared, →IDLE.
  - Count 0 (IDLE): ignored, no pulse.
- DONE: all keys ignored. The buffer clears and count goes to 0; next state IDLE unconditionally.
- Codes 0xC–0xF: no effect on buffer or state; in COLLECT they reload the timeout counter.
- `pin_out` digits hold the last issued PIN until the next issue; `status` is high only in the cycle after the accepting enter.
- Timeout counter:
  - Active only in COLLECT; cleared in IDLE/DONE.
  - Reloads to 0 on any `key_valid`; width is $clog2(TIMEOUT_CYCLES)+1.
  - On reaching TIMEOUT_CYCLES−1 with no key that cycle: buffer cleared, `timeout` pulse, →IDLE.
- `enable`=0:
  - Buffer cleared, count 0, →IDLE; keys ignored.
  - No `timeout`/`entry_error` pulse.
  - A DONE in progress still completes its `status` cycle.
- Simultaneous events:
  - Key and timeout expiry in the same cycle: the key wins, the counter reloads and no timeout occurs.
  - `enable`=0 and key in the same cycle: the abort wins.

## Timing
- Reset values: `pin_out` all digits 0, `status` 0; `digit_count` 0; `entry_error` 0; `timeout` 0; state IDLE; counter 0.
- Reset asserted mid-entry or in DONE: the next cycle shows reset values and no strobe is emitted.
- Latency:
  - Key sampled at edge E → `digit_count`/buffer update visible after E.
  - Enter at edge E → `pin_out.status`=1 for exactly the cycle after E, with digits valid in the same cycle.
  - `digit_count` reads 0 from edge E+1.
- Back-to-back: the earliest next accepted digit is at edge E+2 (a key at E+1 falls in DONE and is ignored).
- Error/timeout pulses are registered and last one cycle after the triggering edge.
- Timeout: last key at edge K, no keys after → `timeout` high in the cycle after edge K+TIMEOUT_CYCLES−1.

## Test plan
- Keys 1,2,3,4,enter on separate cycles → one cycle later `status`=1 with `{digit4..digit1}`=0x1234; `digit_count` sequence 1,2,3,4,0; `status` low again the next cycle.
- Keys 9,8,7,6,5,enter → fifth digit ignored; packet 0x9876.
- Keys 4,2,enter → `entry_error` pulse one cycle; no `status`; count 0; `pin_out` still holds the previous PIN 0x9876.
- TIMEOUT_CYCLES=8: key 7 then idle → `timeout` pulse in the 8th cycle after the key edge and count 0. Key 0xE at idle cycle 6 → no timeout until 8 cycles after that key.
- Keys 1,2, clear, 5,6,7,8, enter → packet 0x5678. Enter followed by key 3 on the very next cycle → 3 ignored, count stays 0.
- Keys 1,2,3 then `rst` for one cycle → all outputs 0. Keys 1,2 then `enable`=0 → count 0 with no pulses; subsequent keys ignored until `enable`=1.
